// File: rtl/serial_subtractor_64bit.sv
// serial_subtractor_64bit: digit-serial a - b - bin, one DIGIT slice per cycle, LSB first.
module serial_subtractor_64bit #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] acc_nx;
  logic             last;

  always_comb begin
    sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, ~borrow_q};
    acc_nx = WIDTH'({sum[DIGIT-1:0], acc_q} >> DIGIT);
    last = cnt_q == CW'(STEPS - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    borrow_d = borrow_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d = ovf_q;
    if (state_q == RUN) begin
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      acc_d = acc_nx;
      borrow_d = ~sum[DIGIT];
      cnt_d = cnt_q + CW'(1);
      state_d = last ? DONE : RUN;
      if (last) begin
        diff_d = acc_nx;
        bout_d = ~sum[DIGIT];
        ovf_d = (a_msb_q ^ b_msb_q) & (acc_nx[WIDTH-1] ^ a_msb_q);
      end
    end else if (start) begin
      // IDLE and DONE accept a new request identically
      a_d = a;
      b_d = b;
      acc_d = '0;
      borrow_d = bin;
      cnt_d = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      borrow_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q <= ovf_d;
    end
  end

  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_subtractor_64bit.sv
// tb_serial_subtractor_64bit: directed and random checks of the serial subtractor, DIGIT=8 and DIGIT=1.
module tb_serial_subtractor_64bit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, bin = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        busy0, done0, bout0, ovf0, busy1, done1, bout1, ovf1;
  logic [63:0] diff0, diff1;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_64bit #(.WIDTH(64), .DIGIT(8)) dut (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b), .bin(bin),
    .busy(busy0), .done(done0), .diff(diff0), .bout(bout0), .ovf(ovf0)
  );

  serial_subtractor_64bit #(.WIDTH(64), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input bit sel, input logic [63:0] ta, input logic [63:0] tb_, input logic tbin,
                    output int lat, output int bcnt);
    a = ta;
    b = tb_;
    bin = tbin;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    start1 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!(sel ? done1 : done0) && lat < 200) begin
      bcnt += int'(sel ? busy1 : busy0);
      @(posedge clk);
      #1 lat++;
    end
    bcnt += int'(sel ? busy1 : busy0);
  endtask

  task automatic check_op(input string tag, input bit sel, input logic [63:0] ta, input logic [63:0] tb_,
                          input logic tbin);
    int lat, bcnt;
    logic [63:0] d_ref;
    logic signed [65:0] exact;
    logic bout_ref, ovf_ref;
    d_ref = ta - tb_ - 64'(tbin);
    bout_ref = {1'b0, ta} < {1'b0, tb_} + 65'(tbin);
    exact = $signed({{2{ta[63]}}, ta}) - $signed({{2{tb_[63]}}, tb_}) - 66'(tbin);
    ovf_ref = exact != $signed({{2{d_ref[63]}}, d_ref});
    op(sel, ta, tb_, tbin, lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), sel ? 64'd64 : 64'd8);
    chk({tag, "_busy"}, 64'(bcnt), sel ? 64'd64 : 64'd8);
    chk({tag, "_diff"}, sel ? diff1 : diff0, d_ref);
    chk({tag, "_bout"}, 64'(sel ? bout1 : bout0), 64'(bout_ref));
    chk({tag, "_ovf"}, 64'(sel ? ovf1 : ovf0), 64'(ovf_ref));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(sel ? done1 : done0), 64'd0);
    chk({tag, "_hold"}, sel ? diff1 : diff0, d_ref);
  endtask

  initial begin
    int lat, holds, ndone;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {60'd0, busy0, done0, bout0, ovf0}, 64'd0);
    chk("reset_diff", diff0, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_op("basic", 1'b0, 64'd100, 64'd1, 1'b0);
    check_op("ripple", 1'b0, 64'd0, 64'd1, 1'b0);
    check_op("sovf", 1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    check_op("binpath", 1'b0, 64'd5, 64'd5, 1'b1);
    chk("binpath_allones", diff0, 64'hFFFF_FFFF_FFFF_FFFF);
    // start held high through RUN must not restart; second op accepted in done cycle
    a = 64'd10;
    b = 64'd3;
    bin = 1'b0;
    start0 = 1'b1;
    @(posedge clk);
    #1 a = 64'd50;
    b = 64'd20;
    lat = 0;
    while (!done0 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("hs_lat1", 64'(lat), 64'd8);
    chk("hs_diff1", diff0, 64'd7);
    @(posedge clk);
    #1 start0 = 1'b0;
    chk("hs_busy2", 64'(busy0), 64'd1);
    lat = 0;
    holds = 0;
    while (!done0 && lat < 200) begin
      holds += int'(diff0 == 64'd7);
      @(posedge clk);
      #1 lat++;
    end
    chk("hs_lat2", 64'(lat), 64'd8);
    chk("hs_hold7", 64'(holds), 64'd8);
    chk("hs_diff2", diff0, 64'd30);
    @(posedge clk);
    #1;
    // asynchronous reset mid-operation
    a = 64'd123;
    b = 64'd45;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_flags", {60'd0, busy0, done0, bout0, ovf0}, 64'd0);
    chk("rst_diff", diff0, 64'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk);
      #1 ndone += int'(done0);
    end
    rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1 ndone += int'(done0);
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    check_op("after_rst", 1'b0, 64'd9, 64'd4, 1'b0);
    chk("after_rst_five", diff0, 64'd5);
    for (int i = 0; i < 6; i++)
      check_op("rand8", 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    check_op("d1_sovf", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    for (int i = 0; i < 6; i++)
      check_op("rand1", 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
